// File: rtl/uart_rx_parity_frame_checker.sv
// UART RX parity/frame checker: masks, checks parity and stop bits, counts errors.
// Define UART_BREAK_DET_EN to add break detection (out_break, cnt_break).
module uart_rx_parity_frame_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_par_en,
    input  logic [1:0]        cfg_par_mode,
    input  logic [3:0]        cfg_data_len,
    input  logic              cfg_two_stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic [1:0]        in_stop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par_err,
    output logic              out_frm_err,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_par_err,
    output logic [CNT_W-1:0]  cnt_frm_err
`ifdef UART_BREAK_DET_EN
    ,
    output logic              out_break,
    output logic [CNT_W-1:0]  cnt_break
`endif
);

    localparam logic [3:0] MAX_LEN = 4'(DATA_W);

    logic              accept;
    logic [3:0]        len_eff;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] data_m;
    logic              par_exp;
    logic              par_raw;
    logic              frm_raw;
    logic              par_err;
    logic              frm_err;

    assign in_ready = rst_n & (!out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        len_eff = cfg_data_len;
        if (cfg_data_len < 4'd5)
            len_eff = 4'd5;
        else if (cfg_data_len > MAX_LEN)
            len_eff = MAX_LEN;
        mask = '0;
        for (int i = 0; i < DATA_W; i++)
            mask[i] = (4'(i) < len_eff);
    end

    assign data_m = in_data & mask;

    always_comb begin
        par_exp = 1'b0;
        unique case (cfg_par_mode)
            2'b00: par_exp = ^data_m;
            2'b01: par_exp = ~(^data_m);
            2'b10: par_exp = 1'b1;
            2'b11: par_exp = 1'b0;
        endcase
    end

    assign par_raw = cfg_par_en & (in_par != par_exp);
    assign frm_raw = !in_stop[0] | (cfg_two_stop & !in_stop[1]);

`ifdef UART_BREAK_DET_EN
    logic brk;
    // A line held low for a whole frame is a break, not a bad character.
    assign brk     = (data_m == '0) & (!cfg_par_en | !in_par) & !in_stop[0];
    assign par_err = par_raw & !brk;
    assign frm_err = frm_raw & !brk;
`else
    assign par_err = par_raw;
    assign frm_err = frm_raw;
`endif

    function automatic logic [CNT_W-1:0] next_cnt(
        input logic [CNT_W-1:0] c,
        input logic             inc,
        input logic             clr
    );
        if (clr)
            return '0;
        if (inc && c != '1)
            return c + 1'b1;
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_par_err <= 1'b0;
            out_frm_err <= 1'b0;
            cnt_par_err <= '0;
            cnt_frm_err <= '0;
`ifdef UART_BREAK_DET_EN
            out_break   <= 1'b0;
            cnt_break   <= '0;
`endif
        end else begin
            if (accept) begin
                out_valid   <= 1'b1;
                out_data    <= data_m;
                out_par_err <= par_err;
                out_frm_err <= frm_err;
`ifdef UART_BREAK_DET_EN
                out_break   <= brk;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            cnt_par_err <= next_cnt(cnt_par_err, accept & par_err, cnt_clr);
            cnt_frm_err <= next_cnt(cnt_frm_err, accept & frm_err, cnt_clr);
`ifdef UART_BREAK_DET_EN
            cnt_break   <= next_cnt(cnt_break, accept & brk, cnt_clr);
`endif
        end
    end

endmodule
